rv_run_ctrl: RTL and testbench
==============================

RV_RUN_CTRL -- requirements
Module: rv_run_ctrl

Interface
REQ-001 SHALL have parameter IMEM_WORDS, default 1024, meaning instruction memory depth in 32-bit words.
REQ-002 SHALL have parameter CORE_RST_CYCLES, default 4, meaning cycles that core_rst_n is held low after load.
REQ-003 SHALL have parameter TIMEOUT, default 32'd1000000, meaning maximum RUN cycles before abort.
REQ-004 SHALL have parameter DONE_ADDR, default 32'h00002000, meaning completion-mailbox byte address.
REQ-005 SHALL have parameter DONE_VALUE, default 32'hCAFEBABE, meaning the pass signature.
REQ-006 SHALL have port clk  input  1  the single clock; all logic is rising-edge.
REQ-007 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-008 SHALL have port start  input  1  level; sampled only in IDLE.
REQ-009 SHALL have port abort  input  1  returns to IDLE from any state.
REQ-010 SHALL have ports ld_valid/ld_ready/ld_data/ld_last  in/out/in/in  1/1/32/1  program-word stream.
REQ-011 SHALL have ports imem_we/imem_waddr/imem_wdata  output  1/32/32  instruction-memory write port; byte address.
REQ-012 SHALL have port core_rst_n  output  1  active-low reset to the pipelined core.
REQ-013 SHALL have ports dmem_we/dmem_addr/dmem_wdata  input  1/32/32  snoop of the core data-memory port.
REQ-014 SHALL have outputs busy, done, pass, timed_out, load_err  1 each; cycle_count 32; word_count 16.

Function
REQ-015 SHALL implement FSM states IDLE, LOAD, HOLD, RUN, FINISH.
REQ-016 SHALL go IDLE->LOAD when start=1; all of done/pass/timed_out/load_err/counters clear on that transition.
REQ-017 SHALL drive ld_ready=1 only in LOAD; a word transfers on ld_valid && ld_ready.
REQ-018 SHALL on each transfer assert imem_we for that same cycle (combinational), imem_waddr = word_count<<2, imem_wdata = ld_data; word_count increments by 1.
REQ-019 SHALL go LOAD->HOLD on a transfer with ld_last=1 (that word is written).
REQ-020 SHALL, if a transfer occurs with word_count == IMEM_WORDS, not write it, set load_err and go FINISH (pass=0).
REQ-021 SHALL hold core_rst_n=0 in every state except RUN.
REQ-022 SHALL stay in HOLD exactly CORE_RST_CYCLES cycles, then enter RUN.
REQ-023 SHALL in RUN increment cycle_count each cycle, saturating at 32'hFFFFFFFF.
REQ-024 SHALL in RUN, on dmem_we && dmem_addr==DONE_ADDR, go FINISH with pass = (dmem_wdata==DONE_VALUE).
REQ-025 SHALL in RUN go FINISH with timed_out=1, pass=0 when cycle_count reaches TIMEOUT; a mailbox write in that same cycle takes priority.
REQ-026 SHALL ignore dmem_* inputs outside RUN.
REQ-027 SHALL assert done=1 in FINISH, holding status and counters until start returns FINISH->LOAD directly.
REQ-028 SHALL on abort=1 go IDLE next cycle from any state, clearing status; abort overrides all other transitions.
REQ-029 SHALL drive busy=1 in LOAD, HOLD, RUN.

Reset
REQ-030 SHALL on rst=1 at a clock edge enter IDLE, core_rst_n=0, ld_ready=0, imem_we=0, all status 0, counters 0.
REQ-031 SHALL treat rst mid-LOAD or mid-RUN identically to REQ-030; rst overrides abort and start.

Structure
REQ-032 SHALL take FSM state encoding, DONE_ADDR and DONE_VALUE defaults from a shared package rv_pkg (also used by the core).
REQ-033 SHALL place the HOLD/TIMEOUT down/up counting in one sub-module rv_cycle_timer (load, enable, count, expire).
REQ-034 SHALL register all status outputs; only ld_ready and imem_* are combinational from state and inputs.

Verification
REQ-035 SHALL cover: start, 3 words 0x00000013 (last on 3rd) -> imem writes at 0x0/0x4/0x8, word_count=3, HOLD 4 cycles, then core_rst_n=1.
REQ-036 SHALL cover: RUN, cycle 10 dmem write 0x2000 <- 0xCAFEBABE -> done=1, pass=1, cycle_count=10, core_rst_n=0 next cycle.
REQ-037 SHALL cover: RUN, dmem write 0x2000 <- 0xDEADBEEF -> done=1, pass=0, timed_out=0.
REQ-038 SHALL cover: TIMEOUT=20, no mailbox write -> timed_out=1 after 20 RUN cycles; mailbox write in cycle 20 -> pass=1, timed_out=0.
REQ-039 SHALL cover: IMEM_WORDS=2, 3 words without ld_last -> third not written, load_err=1, done=1.
REQ-040 SHALL cover: rst pulse mid-LOAD and abort mid-RUN -> IDLE, all outputs reset values, ld_valid stalls honored (no write while ld_valid=0).

Source files
------------

// File: rtl/rv_pkg.sv
// Shared definitions for the RISC-V run controller and the core it supervises.
package rv_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_HOLD   = 3'd2,
      ST_RUN    = 3'd3,
      ST_FINISH = 3'd4
   } run_state_e;

   localparam logic [31:0] DONE_ADDR_DEF  = 32'h0000_2000;
   localparam logic [31:0] DONE_VALUE_DEF = 32'hCAFE_BABE;

   function automatic logic [31:0] word_to_byte_addr(input logic [15:0] idx);
      return {14'd0, idx, 2'b00};
   endfunction

endpackage

// File: rtl/rv_cycle_timer.sv
// Core-reset hold down-counter plus saturating run-cycle up-counter with timeout detect.
module rv_cycle_timer (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        hold_load_i,
   input  logic [31:0] hold_len_i,
   input  logic        hold_en_i,
   output logic        hold_done_o,
   input  logic        run_clr_i,
   input  logic        run_en_i,
   input  logic [31:0] run_limit_i,
   output logic [31:0] run_count_o,
   output logic        run_expire_o
);

   logic [31:0] hold_q, hold_d;
   logic [31:0] run_q, run_d;
   logic [32:0] run_inc;

   always_comb begin
      hold_d = hold_q;
      if (hold_load_i) begin
         hold_d = hold_len_i;
      end else if (hold_en_i && (hold_q != 32'd0)) begin
         hold_d = hold_q - 32'd1;
      end
      hold_done_o = hold_en_i && (hold_q == 32'd0);
   end

   // Expiry looks at the value the counter is about to take, so the limit is reached in-cycle.
   always_comb begin
      run_inc      = {1'b0, run_q} + 33'd1;
      run_expire_o = run_en_i && (run_inc >= {1'b0, run_limit_i});
      run_d        = run_q;
      if (run_clr_i) begin
         run_d = 32'd0;
      end else if (run_en_i) begin
         run_d = run_inc[32] ? 32'hFFFF_FFFF : run_inc[31:0];
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         hold_q <= 32'd0;
         run_q  <= 32'd0;
      end else begin
         hold_q <= hold_d;
         run_q  <= run_d;
      end
   end

   assign run_count_o = run_q;

endmodule

// File: rtl/rv_run_ctrl.sv
// Program loader and run supervisor: streams a program into IMEM, releases the core,
// and watches the completion mailbox or a timeout.
module rv_run_ctrl
   import rv_pkg::*;
#(
   parameter int          IMEM_WORDS      = 1024,
   parameter int          CORE_RST_CYCLES = 4,
   parameter logic [31:0] TIMEOUT         = 32'd1000000,
   parameter logic [31:0] DONE_ADDR       = DONE_ADDR_DEF,
   parameter logic [31:0] DONE_VALUE      = DONE_VALUE_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        abort,
   input  logic        ld_valid,
   output logic        ld_ready,
   input  logic [31:0] ld_data,
   input  logic        ld_last,
   output logic        imem_we,
   output logic [31:0] imem_waddr,
   output logic [31:0] imem_wdata,
   output logic        core_rst_n,
   input  logic        dmem_we,
   input  logic [31:0] dmem_addr,
   input  logic [31:0] dmem_wdata,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic        timed_out,
   output logic        load_err,
   output logic [31:0] cycle_count,
   output logic [15:0] word_count
);

   localparam logic [15:0] IMEM_LIMIT = 16'(IMEM_WORDS);
   localparam logic [31:0] HOLD_LOAD  = (CORE_RST_CYCLES > 0) ? 32'(CORE_RST_CYCLES - 1) : 32'd0;

   run_state_e  state_q, state_d;
   logic [15:0] word_count_q, word_count_d;
   logic        done_q, done_d;
   logic        pass_q, pass_d;
   logic        timed_out_q, timed_out_d;
   logic        load_err_q, load_err_d;
   logic        busy_q, busy_d;
   logic        core_rst_n_q, core_rst_n_d;

   logic        xfer, wr_ovf, mailbox_hit, restart;
   logic        hold_done, run_expire, run_clr, run_en;
   logic [31:0] run_count;

   assign ld_ready    = (state_q == ST_LOAD);
   assign xfer        = ld_valid && ld_ready;
   assign wr_ovf      = (word_count_q == IMEM_LIMIT);
   assign imem_we     = xfer && !wr_ovf;
   assign imem_waddr  = word_to_byte_addr(word_count_q);
   assign imem_wdata  = ld_data;
   assign mailbox_hit = (state_q == ST_RUN) && dmem_we && (dmem_addr == DONE_ADDR);
   assign restart     = ((state_q == ST_IDLE) || (state_q == ST_FINISH)) && start;
   assign run_clr     = abort || restart;
   assign run_en      = (state_q == ST_RUN) && !abort;

   rv_cycle_timer u_timer (
      .clk_i        (clk),
      .rst_i        (rst),
      .hold_load_i  (state_q != ST_HOLD),
      .hold_len_i   (HOLD_LOAD),
      .hold_en_i    (state_q == ST_HOLD),
      .hold_done_o  (hold_done),
      .run_clr_i    (run_clr),
      .run_en_i     (run_en),
      .run_limit_i  (TIMEOUT),
      .run_count_o  (run_count),
      .run_expire_o (run_expire)
   );

   always_comb begin
      state_d      = state_q;
      word_count_d = word_count_q;
      pass_d       = pass_q;
      timed_out_d  = timed_out_q;
      load_err_d   = load_err_q;
      unique case (state_q)
         ST_IDLE, ST_FINISH: begin
            if (start) begin
               state_d      = ST_LOAD;
               word_count_d = 16'd0;
               pass_d       = 1'b0;
               timed_out_d  = 1'b0;
               load_err_d   = 1'b0;
            end
         end
         ST_LOAD: begin
            if (xfer) begin
               if (wr_ovf) begin
                  load_err_d = 1'b1;
                  pass_d     = 1'b0;
                  state_d    = ST_FINISH;
               end else begin
                  word_count_d = word_count_q + 16'd1;
                  if (ld_last) state_d = ST_HOLD;
               end
            end
         end
         ST_HOLD: begin
            if (hold_done) state_d = ST_RUN;
         end
         ST_RUN: begin
            // A mailbox write wins over a timeout landing in the same cycle.
            if (mailbox_hit) begin
               state_d = ST_FINISH;
               pass_d  = (dmem_wdata == DONE_VALUE);
            end else if (run_expire) begin
               state_d     = ST_FINISH;
               timed_out_d = 1'b1;
               pass_d      = 1'b0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (abort) begin
         state_d      = ST_IDLE;
         word_count_d = 16'd0;
         pass_d       = 1'b0;
         timed_out_d  = 1'b0;
         load_err_d   = 1'b0;
      end
      done_d       = (state_d == ST_FINISH);
      busy_d       = (state_d == ST_LOAD) || (state_d == ST_HOLD) || (state_d == ST_RUN);
      core_rst_n_d = (state_d == ST_RUN);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         word_count_q <= 16'd0;
         done_q       <= 1'b0;
         pass_q       <= 1'b0;
         timed_out_q  <= 1'b0;
         load_err_q   <= 1'b0;
         busy_q       <= 1'b0;
         core_rst_n_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         word_count_q <= word_count_d;
         done_q       <= done_d;
         pass_q       <= pass_d;
         timed_out_q  <= timed_out_d;
         load_err_q   <= load_err_d;
         busy_q       <= busy_d;
         core_rst_n_q <= core_rst_n_d;
      end
   end

   assign done        = done_q;
   assign pass        = pass_q;
   assign timed_out   = timed_out_q;
   assign load_err    = load_err_q;
   assign busy        = busy_q;
   assign core_rst_n  = core_rst_n_q;
   assign word_count  = word_count_q;
   assign cycle_count = run_count;

endmodule

// File: tb/tb_rv_run_ctrl.sv
// Directed bench for rv_run_ctrl: main instance (TIMEOUT=20) and a 2-word IMEM instance.
module tb_rv_run_ctrl;

   logic        clk = 1'b0;
   logic        rst, start, abort, ld_valid, ld_last, dmem_we;
   logic [31:0] ld_data, dmem_addr, dmem_wdata;

   logic        ld_ready, imem_we, core_rst_n, busy, done, pass, timed_out, load_err;
   logic [31:0] imem_waddr, imem_wdata, cycle_count;
   logic [15:0] word_count;

   logic        s_ld_ready, s_imem_we, s_core_rst_n, s_busy, s_done, s_pass, s_timed_out, s_load_err;
   logic [31:0] s_imem_waddr, s_imem_wdata, s_cycle_count;
   logic [15:0] s_word_count;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   rv_run_ctrl #(.TIMEOUT(32'd20)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data), .ld_last(ld_last),
      .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
      .core_rst_n(core_rst_n),
      .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .busy(busy), .done(done), .pass(pass), .timed_out(timed_out), .load_err(load_err),
      .cycle_count(cycle_count), .word_count(word_count)
   );

   rv_run_ctrl #(.IMEM_WORDS(2)) dut_s (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .ld_valid(ld_valid), .ld_ready(s_ld_ready), .ld_data(ld_data), .ld_last(ld_last),
      .imem_we(s_imem_we), .imem_waddr(s_imem_waddr), .imem_wdata(s_imem_wdata),
      .core_rst_n(s_core_rst_n),
      .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .busy(s_busy), .done(s_done), .pass(s_pass), .timed_out(s_timed_out), .load_err(s_load_err),
      .cycle_count(s_cycle_count), .word_count(s_word_count)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_load();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic load_one_and_run();
      ld_valid = 1'b1; ld_data = 32'h0000_0013; ld_last = 1'b1;
      tick();
      ld_valid = 1'b0; ld_last = 1'b0;
      for (int i = 0; i < 10 && core_rst_n !== 1'b1; i++) tick();
      check("enter_run", 32'(core_rst_n), 1);
      check("run_cnt0", cycle_count, 0);
   endtask

   task automatic mailbox(input logic [31:0] addr, input logic [31:0] data);
      dmem_we = 1'b1; dmem_addr = addr; dmem_wdata = data;
      tick();
      dmem_we = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; start = 1'b0; abort = 1'b0;
      ld_valid = 1'b0; ld_last = 1'b0; ld_data = 32'd0;
      dmem_we = 1'b0; dmem_addr = 32'd0; dmem_wdata = 32'd0;
      repeat (2) tick();
      rst = 1'b0;

      // reset state
      ld_valid = 1'b1; #1;
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_pass", 32'(pass), 0);
      check("rst_tmo", 32'(timed_out), 0);
      check("rst_lerr", 32'(load_err), 0);
      check("rst_core", 32'(core_rst_n), 0);
      check("rst_ready", 32'(ld_ready), 0);
      check("rst_we", 32'(imem_we), 0);
      check("rst_cyc", cycle_count, 0);
      check("rst_wc", 32'(word_count), 0);
      ld_valid = 1'b0;

      // three-word load with a stall, then core reset hold
      start_load();
      check("ld_busy", 32'(busy), 1);
      check("ld_ready", 32'(ld_ready), 1);
      check("ld_core", 32'(core_rst_n), 0);
      for (int i = 0; i < 3; i++) begin
         if (i == 1) begin
            ld_valid = 1'b0; #1;
            check("stall_we", 32'(imem_we), 0);
            tick();
            check("stall_wc", 32'(word_count), 1);
         end
         ld_valid = 1'b1; ld_data = 32'h0000_0013; ld_last = (i == 2); #1;
         check("wr_we", 32'(imem_we), 1);
         check("wr_addr", imem_waddr, 32'(i * 4));
         check("wr_data", imem_wdata, 32'h0000_0013);
         tick();
      end
      ld_valid = 1'b0; ld_last = 1'b0;
      check("ld_wc3", 32'(word_count), 3);
      check("hold_ready", 32'(ld_ready), 0);
      dmem_we = 1'b1; dmem_addr = 32'h2000; dmem_wdata = 32'hCAFE_BABE;
      for (int i = 0; i < 4; i++) begin
         check("hold_core", 32'(core_rst_n), 0);
         check("hold_busy", 32'(busy), 1);
         tick();
      end
      dmem_we = 1'b0;
      check("run_core", 32'(core_rst_n), 1);
      check("run_nodone", 32'(done), 0);
      check("run_cyc0", cycle_count, 0);

      // pass signature at run cycle 10, wrong-address write at cycle 5 ignored
      for (int k = 1; k <= 9; k++) begin
         if (k == 5) begin
            dmem_we = 1'b1; dmem_addr = 32'h2004; dmem_wdata = 32'hCAFE_BABE;
         end
         tick();
         dmem_we = 1'b0;
      end
      check("run_cyc9", cycle_count, 9);
      check("run_done9", 32'(done), 0);
      mailbox(32'h2000, 32'hCAFE_BABE);
      check("pass_done", 32'(done), 1);
      check("pass_pass", 32'(pass), 1);
      check("pass_tmo", 32'(timed_out), 0);
      check("pass_cyc", cycle_count, 10);
      check("pass_core", 32'(core_rst_n), 0);
      check("pass_busy", 32'(busy), 0);
      tick();
      check("fin_done", 32'(done), 1);
      check("fin_cyc", cycle_count, 10);

      // restart from FINISH, wrong signature
      start_load();
      check("re_done", 32'(done), 0);
      check("re_pass", 32'(pass), 0);
      check("re_busy", 32'(busy), 1);
      check("re_cyc", cycle_count, 0);
      check("re_wc", 32'(word_count), 0);
      check("re_ready", 32'(ld_ready), 1);
      load_one_and_run();
      mailbox(32'h2000, 32'hDEAD_BEEF);
      check("bad_done", 32'(done), 1);
      check("bad_pass", 32'(pass), 0);
      check("bad_tmo", 32'(timed_out), 0);
      check("bad_cyc", cycle_count, 1);

      // timeout after 20 run cycles
      start_load();
      load_one_and_run();
      repeat (19) tick();
      check("tmo_pre_done", 32'(done), 0);
      check("tmo_pre_cyc", cycle_count, 19);
      tick();
      check("tmo_done", 32'(done), 1);
      check("tmo_flag", 32'(timed_out), 1);
      check("tmo_pass", 32'(pass), 0);
      check("tmo_cyc", cycle_count, 20);

      // mailbox in the timeout cycle wins
      start_load();
      load_one_and_run();
      repeat (19) tick();
      mailbox(32'h2000, 32'hCAFE_BABE);
      check("edge_done", 32'(done), 1);
      check("edge_pass", 32'(pass), 1);
      check("edge_tmo", 32'(timed_out), 0);
      check("edge_cyc", cycle_count, 20);

      // abort mid-run, with start asserted alongside
      start_load();
      load_one_and_run();
      repeat (3) tick();
      abort = 1'b1; start = 1'b1;
      tick();
      abort = 1'b0; start = 1'b0;
      check("ab_busy", 32'(busy), 0);
      check("ab_done", 32'(done), 0);
      check("ab_cyc", cycle_count, 0);
      check("ab_wc", 32'(word_count), 0);
      check("ab_core", 32'(core_rst_n), 0);
      check("ab_ready", 32'(ld_ready), 0);
      tick();
      check("ab_idle", 32'(busy), 0);

      // reset pulse mid-load
      start_load();
      ld_valid = 1'b1; ld_data = 32'h0000_0013; ld_last = 1'b0;
      tick();
      check("ml_wc", 32'(word_count), 1);
      rst = 1'b1;
      tick();
      rst = 1'b0; #1;
      check("ml_wc0", 32'(word_count), 0);
      check("ml_busy", 32'(busy), 0);
      check("ml_ready", 32'(ld_ready), 0);
      check("ml_we", 32'(imem_we), 0);
      ld_valid = 1'b0;

      // IMEM overflow on the 2-word instance
      start_load();
      check("ov_ready", 32'(s_ld_ready), 1);
      for (int i = 0; i < 3; i++) begin
         ld_valid = 1'b1; ld_data = 32'h0000_0100 + 32'(i); ld_last = 1'b0; #1;
         check("ov_we", 32'(s_imem_we), (i < 2) ? 1 : 0);
         if (i < 2) check("ov_addr", s_imem_waddr, 32'(i * 4));
         tick();
      end
      ld_valid = 1'b0;
      check("ov_done", 32'(s_done), 1);
      check("ov_lerr", 32'(s_load_err), 1);
      check("ov_pass", 32'(s_pass), 0);
      check("ov_busy", 32'(s_busy), 0);
      check("ov_core", 32'(s_core_rst_n), 0);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("ov_ab_done", 32'(s_done), 0);
      check("ov_ab_lerr", 32'(s_load_err), 0);
      check("ov_ab_busy", 32'(busy), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
